err_monitor: RTL

- Producer side of the MEDAC phase-control loop.
- Consumes raw per-cycle mismatch bits from the three shadow-sampling comparators (lagging, origin and leading sampling phases).
- Filters them over an observation window, then issues single-cycle error_lagging / error_origin / error_leading pulses to the phase controller, which selects clk_sel.
- Applies a holdoff after each report so the controller's phase change settles before new evidence is gathered.

---
 rtl/medac_pkg.sv | 35 +++
 rtl/sat_counter.sv | 35 +++
 rtl/err_monitor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/medac_pkg.sv
// Shared types for the MEDAC error monitor: FSM states, clk_sel codes
// and the fixed report priority used when several channels fire at once.
package medac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OBSERVE = 2'd1,
    ST_REPORT  = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  localparam logic [1:0] SEL_LEAD = 2'b00;
  localparam logic [1:0] SEL_ORIG = 2'b01;
  localparam logic [1:0] SEL_LAG  = 2'b10;

  typedef struct packed {
    logic lag;
    logic orig;
    logic lead;
  } err_t;

  // Lagging wins, then leading, then origin.
  function automatic err_t prio_pick(input err_t hit);
    err_t r;
    r = '0;
    priority case (1'b1)
      hit.lag:  r.lag  = 1'b1;
      hit.lead: r.lead = 1'b1;
      hit.orig: r.orig = 1'b1;
      default:  r      = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Per-channel saturating mismatch counter; o_at_thresh looks at the
// value this edge would store, so a channel can fire on the sample itself.
module sat_counter #(
  parameter int W      = 6,
  parameter int THRESH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_at_thresh
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_next;

  assign w_next = (i_inc && r_cnt != MAX) ? r_cnt + 1'b1 : r_cnt;

  assign o_at_thresh = (w_next >= W'(THRESH));
  assign o_count     = r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

endmodule

// File: rtl/err_monitor.sv
// Filters shadow-compare mismatches over a window and emits one-cycle
// phase error reports, then holds off while the controller settles.
module err_monitor
  import medac_pkg::*;
#(
  parameter int WINDOW  = 64,
  parameter int CNT_W   = 6,
  parameter int THRESH  = 4,
  parameter int HOLDOFF = 8,
  parameter int TOT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mismatch_lagging,
  input  logic             mismatch_origin,
  input  logic             mismatch_leading,
  input  logic [1:0]       clk_sel,
  output logic             error_lagging,
  output logic             error_origin,
  output logic             error_leading,
  output logic [TOT_W-1:0] report_total,
  output logic             busy
);

  localparam int WW = $clog2(WINDOW);
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  state_e           r_state;
  logic [1:0]       r_sel_q;
  logic [WW-1:0]    r_win;
  logic [HW-1:0]    r_hold;
  err_t             r_err;
  logic             r_busy;
  logic [TOT_W-1:0] r_total;

  logic               w_phase;
  logic               w_live;
  logic [2:0]         w_inc;
  logic [2:0]         w_hit;
  logic               w_fire;
  logic               w_expire;
  logic               w_clr;
  err_t               w_pick;
  logic [3*CNT_W-1:0] w_unused_cnt;

  assign w_phase = (clk_sel != r_sel_q);
  // Evidence only counts while observing under a stable phase.
  assign w_live  = en && (r_state == ST_OBSERVE) && !w_phase;

  assign w_inc = {3{w_live}} &
                 {mismatch_lagging, mismatch_origin, mismatch_leading};

  assign w_fire   = w_live && (|w_hit);
  assign w_expire = w_live && (r_win == WW'(WINDOW - 1));
  assign w_clr    = !w_live || w_fire || w_expire;
  assign w_pick   = prio_pick(err_t'(w_hit));

  for (genvar i = 0; i < 3; i++) begin : g_ch
    sat_counter #(
      .W      (CNT_W),
      .THRESH (THRESH)
    ) u_cnt (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_inc       (w_inc[i]),
      .i_clr       (w_clr),
      .o_count     (w_unused_cnt[i*CNT_W +: CNT_W]),
      .o_at_thresh (w_hit[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel_q <= SEL_ORIG;
      r_win   <= '0;
      r_hold  <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_total <= '0;
    end else begin
      r_sel_q <= clk_sel;
      r_err   <= '0;
      if (!en) begin
        r_state <= ST_IDLE;
        r_win   <= '0;
        r_hold  <= '0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state <= ST_OBSERVE;
            r_win   <= '0;
          end
          ST_OBSERVE: begin
            if (w_phase) begin
              r_win <= '0;
            end else if (w_fire) begin
              r_state <= ST_REPORT;
              r_err   <= w_pick;
              r_busy  <= 1'b1;
              r_win   <= '0;
              r_total <= (&r_total) ? r_total : r_total + 1'b1;
            end else if (w_expire) begin
              r_win <= '0;
            end else begin
              r_win <= r_win + 1'b1;
            end
          end
          ST_REPORT: begin
            r_state <= ST_HOLD;
            r_hold  <= '0;
          end
          ST_HOLD: begin
            if (r_hold == HW'(HOLDOFF - 1)) begin
              r_state <= ST_OBSERVE;
              r_win   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign error_lagging = r_err.lag;
  assign error_origin  = r_err.orig;
  assign error_leading = r_err.lead;
  assign report_total  = r_total;
  assign busy          = r_busy;

endmodule
